// File: rtl/wb_trace_buffer_pkg.sv
// Shared types and widths for the writeback trace buffer.
// Optional PC capture is selected with the TRACE_PC_EN macro in wb_trace_buffer.
package wb_trace_buffer_pkg;

  localparam int SEQ_W      = 16;
  localparam int DROP_W     = 16;
  localparam int REG_ADDR_W = 5;
  localparam int PC_W       = 32;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [PC_W-1:0]       pc;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
    logic [SEQ_W-1:0]      seq;
  } trace_entry_t;

  // Entry layout without the PC field, used when PC capture is compiled out
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
    logic [SEQ_W-1:0]      seq;
  } trace_entry_nopc_t;

endpackage

// File: rtl/trace_fifo.sv
// Generic first-word-fall-through synchronous FIFO; head word reads as zero when empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is never reset, so mask the head word while nothing valid is held
  assign pop_data = empty ? '0 : mem[rd_ptr_reg];
  assign count    = count_reg;

endmodule

// File: rtl/wb_trace_buffer.sv
// Captures retiring register writes into a FWFT FIFO with sequence numbers and drop accounting.
// Define TRACE_PC_EN to store and present the PC of each captured write.
module wb_trace_buffer
  import wb_trace_buffer_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int SKIP_R0 = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    cap_en,
  input  logic [PC_W-1:0]         cap_pc,
  input  logic                    cap_we,
  input  logic [REG_ADDR_W-1:0]   cap_addr,
  input  logic [DATA_W-1:0]       cap_data,
  output logic                    tr_valid,
  input  logic                    tr_ready,
  output logic [PC_W-1:0]         tr_pc,
  output logic [REG_ADDR_W-1:0]   tr_addr,
  output logic [DATA_W-1:0]       tr_data,
  output logic [SEQ_W-1:0]        tr_seq,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic [DROP_W-1:0]       drop_cnt
);

`ifdef TRACE_PC_EN
  localparam int ENTRY_W = $bits(trace_entry_t);
  trace_entry_t      push_entry;
  trace_entry_t      head_entry;
`else
  localparam int ENTRY_W = $bits(trace_entry_nopc_t);
  trace_entry_nopc_t push_entry;
  trace_entry_nopc_t head_entry;
  logic              unused_pc;
`endif

  logic               skip_r0;
  logic               cap_event;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic               drop;
  logic [ENTRY_W-1:0] head_word;
  logic [SEQ_W-1:0]   seq_reg;
  logic               overflow_reg;
  logic [DROP_W-1:0]  drop_cnt_reg;

  assign skip_r0   = (SKIP_R0 != 0);
  assign cap_event = cap_en & cap_we & ~(skip_r0 & (cap_addr == '0));
  assign tr_valid  = ~fifo_empty;
  assign pop       = tr_valid & tr_ready;
  // A pop in the same cycle frees the slot, so only a full FIFO without a pop drops
  assign drop      = cap_event & fifo_full & ~pop;

`ifdef TRACE_PC_EN
  assign push_entry = '{pc: cap_pc, addr: cap_addr, data: cap_data, seq: seq_reg};
  assign head_entry = head_word;
  assign tr_pc      = head_entry.pc;
`else
  assign push_entry = '{addr: cap_addr, data: cap_data, seq: seq_reg};
  assign head_entry = head_word;
  assign tr_pc      = '0;
  assign unused_pc  = ^cap_pc;
`endif

  assign tr_addr = head_entry.addr;
  assign tr_data = head_entry.data;
  assign tr_seq  = head_entry.seq;

  trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .push      (cap_event & ~clr),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  // Every capture event consumes a sequence number, even when it is dropped
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      seq_reg      <= '0;
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      if (cap_event) begin
        seq_reg <= seq_reg + 1'b1;
      end
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_cnt_reg != '1) begin
          drop_cnt_reg <= drop_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign overflow = overflow_reg;
  assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed self-checking bench for wb_trace_buffer (SKIP_R0=1 main instance, SKIP_R0=0 side instance).
// Expects tr_pc to follow cap_pc only when TRACE_PC_EN is defined.
module tb_wb_trace_buffer;

  logic        clk = 1'b0;
  logic        rst, clr, cap_en, cap_we, tr_ready;
  logic [31:0] cap_pc, cap_data;
  logic [4:0]  cap_addr;

  logic        tr_valid, overflow;
  logic [31:0] tr_pc, tr_data;
  logic [4:0]  tr_addr;
  logic [15:0] tr_seq, drop_cnt;
  logic [4:0]  count;

  logic        b_valid, b_overflow;
  logic [31:0] b_pc, b_data;
  logic [4:0]  b_addr;
  logic [15:0] b_seq, b_drop_cnt;
  logic [4:0]  b_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_trace_buffer #(.DEPTH(16), .SKIP_R0(1)) dut (
    .clk(clk), .rst(rst), .clr(clr), .cap_en(cap_en), .cap_pc(cap_pc),
    .cap_we(cap_we), .cap_addr(cap_addr), .cap_data(cap_data),
    .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_pc(tr_pc), .tr_addr(tr_addr),
    .tr_data(tr_data), .tr_seq(tr_seq), .count(count), .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  wb_trace_buffer #(.DEPTH(16), .SKIP_R0(0)) dut_r0 (
    .clk(clk), .rst(rst), .clr(clr), .cap_en(cap_en), .cap_pc(cap_pc),
    .cap_we(cap_we), .cap_addr(cap_addr), .cap_data(cap_data),
    .tr_valid(b_valid), .tr_ready(tr_ready), .tr_pc(b_pc), .tr_addr(b_addr),
    .tr_data(b_data), .tr_seq(b_seq), .count(b_count), .overflow(b_overflow),
    .drop_cnt(b_drop_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic capture(input logic [31:0] pc, input logic [4:0] addr, input logic [31:0] data);
    cap_we   = 1'b1;
    cap_pc   = pc;
    cap_addr = addr;
    cap_data = data;
    tick();
    cap_we   = 1'b0;
  endtask

  function automatic logic [31:0] exp_pc(input logic [31:0] pc);
`ifdef TRACE_PC_EN
    return pc;
`else
    return (pc & 32'h0);
`endif
  endfunction

  initial begin
    rst = 1'b1; clr = 1'b0; cap_en = 1'b1; cap_we = 1'b1; tr_ready = 1'b0;
    cap_pc = 32'h100; cap_addr = 5'd7; cap_data = 32'h1234;

    // Reset held with write strobe active
    tick(); tick();
    check("rst_valid", 32'(tr_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_pc", tr_pc, 32'd0);
    check("rst_addr", 32'(tr_addr), 32'd0);
    check("rst_data", tr_data, 32'd0);
    check("rst_seq", 32'(tr_seq), 32'd0);
    rst = 1'b0; cap_we = 1'b0;
    tick();
    $display("reset released");

    // Single capture, then pop
    capture(32'h8, 5'd5, 32'hDEADBEEF);
    $display("captured pc=8 addr=5 data=deadbeef");
    check("single_valid", 32'(tr_valid), 32'd1);
    check("single_addr", 32'(tr_addr), 32'd5);
    check("single_data", tr_data, 32'hDEADBEEF);
    check("single_seq", 32'(tr_seq), 32'd0);
    check("single_pc", tr_pc, exp_pc(32'h8));
    tr_ready = 1'b1; tick(); tr_ready = 1'b0;
    check("single_popped", 32'(tr_valid), 32'd0);
    check("single_count", 32'(count), 32'd0);

    // R0 filtering on both instances
    clr = 1'b1; tick(); clr = 1'b0;
    capture(32'h10, 5'd0, 32'hAAAA);
    capture(32'h14, 5'd3, 32'hBBBB);
    $display("captured addr=0 then addr=3");
    check("r0_skip_count", 32'(count), 32'd1);
    check("r0_skip_addr", 32'(tr_addr), 32'd3);
    check("r0_skip_seq", 32'(tr_seq), 32'd0);
    check("r0_keep_count", 32'(b_count), 32'd2);
    check("r0_keep_addr0", 32'(b_addr), 32'd0);
    check("r0_keep_seq0", 32'(b_seq), 32'd0);
    tr_ready = 1'b1; tick();
    check("r0_keep_addr1", 32'(b_addr), 32'd3);
    check("r0_keep_seq1", 32'(b_seq), 32'd1);
    check("r0_skip_empty", 32'(tr_valid), 32'd0);
    tick(); tr_ready = 1'b0;
    check("r0_keep_empty", 32'(b_valid), 32'd0);

    // Overflow: 20 captures into 16 slots
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      capture(32'h400 + 32'(i * 4), 5'(i % 31 + 1), 32'(i));
    end
    $display("20 captures issued, count=%0d drop_cnt=%0d", count, drop_cnt);
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_drop", 32'(drop_cnt), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    tr_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      $display("drain seq=%0d data=%0h", tr_seq, tr_data);
      check("drain_seq", 32'(tr_seq), 32'(i));
      check("drain_data", tr_data, 32'(i));
      check("drain_addr", 32'(tr_addr), 32'(i % 31 + 1));
      tick();
    end
    tr_ready = 1'b0;
    check("drain_empty", 32'(count), 32'd0);
    capture(32'h500, 5'd9, 32'h99);
    check("after_drain_seq", 32'(tr_seq), 32'd20);
    check("after_drain_ovf", 32'(overflow), 32'd1);
    tr_ready = 1'b1; tick(); tr_ready = 1'b0;

    // Full FIFO with simultaneous push and pop
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      capture(32'h600, 5'd2, 32'h100 + 32'(i));
    end
    check("full_count", 32'(count), 32'd16);
    tr_ready = 1'b1;
    capture(32'h700, 5'd4, 32'h200);
    tr_ready = 1'b0;
    $display("push+pop at full, head seq=%0d", tr_seq);
    check("pushpop_count", 32'(count), 32'd16);
    check("pushpop_drop", 32'(drop_cnt), 32'd0);
    check("pushpop_ovf", 32'(overflow), 32'd0);
    check("pushpop_head", 32'(tr_seq), 32'd1);
    check("pushpop_data", tr_data, 32'h101);

    // clr mid-stream with a concurrent capture
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      capture(32'h800, 5'd6, 32'(i));
    end
    check("clr_pre_count", 32'(count), 32'd5);
    clr = 1'b1;
    capture(32'h900, 5'd8, 32'hCAFE);
    clr = 1'b0;
    $display("clr with concurrent capture");
    check("clr_count", 32'(count), 32'd0);
    check("clr_valid", 32'(tr_valid), 32'd0);
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_data", tr_data, 32'd0);
    capture(32'hA00, 5'd10, 32'h77);
    check("clr_next_valid", 32'(tr_valid), 32'd1);
    check("clr_next_seq", 32'(tr_seq), 32'd0);
    check("clr_next_data", tr_data, 32'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
